led_blink_array: RTL and testbench
==================================

LED_BLINK_ARRAY -- requirements
Module: led_blink_array

Interface
REQ-001 Parameter CH, default 4, number of independent LED channels (1..16).
REQ-002 Parameter CW, default 32, per-channel counter and period width (4..32).
REQ-003 Parameter PRESC, default 0, shared tick divider value (tick every PRESC+1 cycles); only used with LED_BLINK_PRESCALE_EN.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: m_clock (input, 1 bit) and p_reset_n (input, 1 bit).
REQ-005 cfg_valid  in  1  configuration write request.
REQ-006 cfg_ch  in  max(1,clog2(CH))  target channel index.
REQ-007 cfg_mode  in  2  mode: 00 OFF, 01 ON, 10 BLINK, 11 ONESHOT.
REQ-008 cfg_period  in  CW  terminal count for the channel.
REQ-009 cfg_ready  out  1  write slot available.
REQ-010 led  out  CH  per-channel LED drive.
REQ-011 wrap  out  CH  one-cycle pulse per channel when its counter reaches terminal count.
REQ-012 busy  out  CH  high while the channel is in ONESHOT.

Function
REQ-013 A write SHALL be accepted on a rising m_clock edge with cfg_valid=1 and cfg_ready=1.
REQ-014 cfg_ready SHALL be 0 for exactly the one cycle after each accepted write and 1 otherwise.
REQ-015 An accepted write SHALL load mode and period, and clear cnt to 0, for channel cfg_ch; the effect SHALL be visible on led/busy in the cycle after the accepting edge.
REQ-016 Writes with cfg_ch >= CH SHALL be accepted and ignored.
REQ-017 OFF: led=0, cnt held at 0, no wrap.
REQ-018 ON: led=1, cnt held at 0, no wrap.
REQ-019 BLINK: led=0 after the write; on each tick, if cnt==period then cnt<=0, led toggles, and wrap pulses for one cycle; otherwise cnt<=cnt+1.
REQ-020 ONESHOT: led=1 and busy=1 after the write; on the tick where cnt==period, led<=0, busy<=0, mode<=OFF, and wrap pulses.
REQ-021 period=0: BLINK SHALL toggle on every tick; ONESHOT SHALL last one tick.
REQ-022 cnt SHALL never exceed period; the CW-bit wrap at all-ones period SHALL use the period comparison, with no overflow path.
REQ-023 A write and a terminal-count event on the same channel in the same cycle: the write SHALL win, with no wrap pulse and no toggle.
REQ-024 Channels SHALL be fully independent; a write to one channel SHALL NOT disturb another channel's cnt or led.

Reset
REQ-025 When p_reset_n=0, all state SHALL clear asynchronously: mode=OFF, period=0, cnt=0, led=0, wrap=0, busy=0, cfg_ready=1, prescaler=0.
REQ-026 Reset deassertion mid-operation SHALL resume from the cleared state; no partial configuration SHALL survive.

Configuration
REQ-027 With LED_BLINK_PRESCALE_EN defined, a shared prescaler SHALL generate tick once every PRESC+1 cycles for all channels.
REQ-028 Without LED_BLINK_PRESCALE_EN, tick SHALL be 1 every cycle, PRESC SHALL be ignored, and no prescaler register SHALL exist.

Structure
REQ-029 The led_blink_pkg package SHALL hold the mode encoding (MODE_OFF, MODE_ON, MODE_BLINK, MODE_ONESHOT) and the MODE_W=2 constant.
REQ-030 A sub-module led_blink_ch SHALL hold one channel (cnt, period, mode, led, wrap, busy) and SHALL be instantiated CH times by generate; the top SHALL hold the decoder, the cfg_ready logic and the prescaler.

Verification (CH=4, CW=8, prescaler off unless stated)
REQ-031 Reset: drive p_reset_n=0 mid-blink -> led=0000, wrap=0000, cfg_ready=1 immediately, without waiting for a clock edge.
REQ-032 BLINK with period=3 on ch0 -> led[0] toggles every 4 cycles; wrap[0] pulses in the cycle of each toggle; ch1..3 stay 0.
REQ-033 ONESHOT with period=5 on ch2 -> led[2]=busy[2]=1 for 6 cycles, then 0 with one wrap[2] pulse; the channel then reads as OFF.
REQ-034 Back-to-back cfg_valid -> every second cycle accepted (cfg_ready pattern 1,0,1,0); a write to cfg_ch=5 has no effect.
REQ-035 Rewrite ch0 in the terminal-count cycle -> no toggle, no wrap pulse, cnt restarts at 0; period=255 BLINK -> toggle every 256 cycles.
REQ-036 With LED_BLINK_PRESCALE_EN and PRESC=9, BLINK with period=1 -> led toggles every 20 cycles.

Source files
------------

// File: rtl/led_blink_pkg.sv
// led_blink_pkg: mode encoding and shared constants for the LED blink array.
// Optional build macro used by the array top: LED_BLINK_PRESCALE_EN.
package led_blink_pkg;

  // Width of the per-channel mode field.
  localparam int MODE_W = 2;

  // Channel modes; these are also the channel FSM state encodings.
  localparam logic [MODE_W-1:0] MODE_OFF     = 2'b00;
  localparam logic [MODE_W-1:0] MODE_ON      = 2'b01;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 2'b10;
  localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'b11;

  // Width of a channel index field; never narrower than one bit.
  function automatic int ch_idx_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // LED level a channel takes immediately after being configured.
  function automatic logic mode_led_init(input logic [MODE_W-1:0] mode);
    return (mode == MODE_ON) || (mode == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/led_blink_array_if.sv
// led_blink_array_if: configuration write port of the LED blink array.
//
// Handshake: a write transfers on a rising clock edge where cfg_valid=1 and
// cfg_ready=1. The master holds cfg_ch/cfg_mode/cfg_period stable while
// cfg_valid=1 and cfg_ready=0. The slave drops cfg_ready for exactly the one
// cycle after every accepted write, so back-to-back requests are taken at
// most every second cycle.
interface led_blink_array_if
  import led_blink_pkg::*;
#(
  parameter int CH = 4,
  parameter int CW = 32
);

  localparam int CHW = ch_idx_w(CH);

  logic              cfg_valid;
  logic [CHW-1:0]    cfg_ch;
  logic [MODE_W-1:0] cfg_mode;
  logic [CW-1:0]     cfg_period;
  logic              cfg_ready;

  // Configuration source (testbench, CPU bridge).
  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_mode,
    output cfg_period,
    input  cfg_ready
  );

  // The blink array itself.
  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_mode,
    input  cfg_period,
    output cfg_ready
  );

endinterface

// File: rtl/led_blink_ch.sv
// led_blink_ch: one LED channel. Holds mode, period, counter and LED level.
// The mode register is the channel state machine (OFF/ON/BLINK/ONESHOT) and
// is exported on dbg_mode. A write always has priority over a terminal-count
// event in the same cycle: it reloads the channel and suppresses the wrap.
module led_blink_ch
  import led_blink_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic              m_clock,
  input  logic              p_reset_n,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [MODE_W-1:0] wr_mode,
  input  logic [CW-1:0]     wr_period,
  output logic              led,
  output logic              wrap,
  output logic              busy,
  output logic [MODE_W-1:0] dbg_mode
);

  logic [MODE_W-1:0] mode_q, mode_d;
  logic [CW-1:0]     period_q, period_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              led_q, led_d;
  logic              wrap_q, wrap_d;
  logic              at_term;

  // Terminal count is an equality compare, so an all-ones period wraps
  // through this path and the increment below can never overflow.
  assign at_term = (cnt_q == period_q);

  // Next-state: write reload first, then per-mode behaviour on a tick.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    wrap_d   = 1'b0;
    if (wr_en) begin
      mode_d   = wr_mode;
      period_d = wr_period;
      cnt_d    = '0;
      led_d    = mode_led_init(wr_mode);
    end else begin
      case (mode_q)
        MODE_OFF: begin
          cnt_d = '0;
          led_d = 1'b0;
        end
        MODE_ON: begin
          cnt_d = '0;
          led_d = 1'b1;
        end
        MODE_BLINK: begin
          if (tick) begin
            if (at_term) begin
              cnt_d  = '0;
              led_d  = ~led_q;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          // ONESHOT: LED held on until the terminal tick, then the channel
          // falls back to OFF by itself.
          if (tick) begin
            if (at_term) begin
              cnt_d  = '0;
              led_d  = 1'b0;
              mode_d = MODE_OFF;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      endcase
    end
  end

  // Channel state registers, cleared asynchronously.
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      mode_q   <= MODE_OFF;
      period_q <= '0;
      cnt_q    <= '0;
      led_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      wrap_q   <= wrap_d;
    end
  end

  assign led      = led_q;
  assign wrap     = wrap_q;
  assign busy     = (mode_q == MODE_ONESHOT);
  assign dbg_mode = mode_q;

endmodule

// File: rtl/led_blink_array.sv
// led_blink_array: CH independent LED channels behind one configuration port.
// The top holds the channel decoder, the cfg_ready throttle and the shared
// tick source. Build macro LED_BLINK_PRESCALE_EN adds a prescaler that ticks
// every PRESC+1 cycles; without it every cycle is a tick and PRESC is unused.
module led_blink_array
  import led_blink_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CW    = 32,
  parameter int PRESC = 0
) (
  input  logic                 m_clock,
  input  logic                 p_reset_n,
  led_blink_array_if.slave     cfg,
  output logic [CH-1:0]        led,
  output logic [CH-1:0]        wrap,
  output logic [CH-1:0]        busy,
  output logic [CH*MODE_W-1:0] dbg_mode
);

  localparam int CHW = ch_idx_w(CH);

  logic          ready_q, ready_d;
  logic          accept;
  logic          tick;
  logic [CH-1:0] wr_en;

  assign accept        = cfg.cfg_valid & ready_q;
  assign cfg.cfg_ready = ready_q;

  // Throttle: ready drops for the single cycle after each accepted write.
  always_comb begin
    ready_d = ~accept;
  end

  // Write slot register; idles ready.
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= ready_d;
    end
  end

  // Channel decoder; indices at or above CH match no channel and are dropped.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < CH; i++) begin
      if (cfg.cfg_ch == CHW'(i)) begin
        wr_en[i] = accept;
      end
    end
  end

`ifdef LED_BLINK_PRESCALE_EN
  localparam logic [31:0] PRESC_TC = 32'(PRESC);

  logic [31:0] presc_q, presc_d;

  // Shared prescaler: count 0..PRESC, tick on the terminal value.
  always_comb begin
    presc_d = (presc_q == PRESC_TC) ? '0 : presc_q + 32'd1;
  end

  // Prescaler register, shared by all channels.
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = (presc_q == PRESC_TC);
`else
  logic presc_unused;

  assign presc_unused = ^PRESC;
  assign tick         = 1'b1;
`endif

  for (genvar g = 0; g < CH; g++) begin : g_ch
    led_blink_ch #(
      .CW (CW)
    ) u_ch (
      .m_clock   (m_clock),
      .p_reset_n (p_reset_n),
      .tick      (tick),
      .wr_en     (wr_en[g]),
      .wr_mode   (cfg.cfg_mode),
      .wr_period (cfg.cfg_period),
      .led       (led[g]),
      .wrap      (wrap[g]),
      .busy      (busy[g]),
      .dbg_mode  (dbg_mode[g*MODE_W +: MODE_W])
    );
  end

endmodule

// File: tb/tb_led_blink_array.sv
// tb_led_blink_array: directed bench for led_blink_array (CH=4, CW=8), plus a
// CH=5 instance for out-of-range channel writes. Build macro
// LED_BLINK_PRESCALE_EN selects the prescaler scenario (PRESC=9).
module tb_led_blink_array;
  import led_blink_pkg::*;

  localparam int CH    = 4;
  localparam int CW    = 8;
  localparam int PRESC = 9;

  // ---------------- clock / reset ----------------
  logic m_clock   = 1'b0;
  logic p_reset_n = 1'b1;

  always #5 m_clock = ~m_clock;

  // ---------------- DUTs ----------------
  led_blink_array_if #(.CH(CH), .CW(CW)) cfg_if ();
  logic [CH-1:0]        led, wrap, busy;
  logic [CH*MODE_W-1:0] dbg_mode;

  led_blink_array #(.CH(CH), .CW(CW), .PRESC(PRESC)) u_dut (
    .m_clock   (m_clock),
    .p_reset_n (p_reset_n),
    .cfg       (cfg_if),
    .led       (led),
    .wrap      (wrap),
    .busy      (busy),
    .dbg_mode  (dbg_mode)
  );

  led_blink_array_if #(.CH(5), .CW(CW)) cfg5_if ();
  logic [4:0] led5, wrap5, busy5;
  logic [9:0] dbg5;

  led_blink_array #(.CH(5), .CW(CW), .PRESC(PRESC)) u_dut5 (
    .m_clock   (m_clock),
    .p_reset_n (p_reset_n),
    .cfg       (cfg5_if),
    .led       (led5),
    .wrap      (wrap5),
    .busy      (busy5),
    .dbg_mode  (dbg5)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  e_led, e_wrap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge m_clock);
    #1;
  endtask

  // Issue one write; returns one cycle after the accepting edge.
  task automatic cfg_wr(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] period);
    int n = 0;
    while (!cfg_if.cfg_ready && n < 4) begin
      step();
      n++;
    end
    chk("wr_ready", 32'(cfg_if.cfg_ready), 32'd1);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = ch;
    cfg_if.cfg_mode   = mode;
    cfg_if.cfg_period = period;
    step();
    cfg_if.cfg_valid  = 1'b0;
  endtask

  task automatic cfg5_wr(input logic [2:0] ch, input logic [1:0] mode);
    cfg5_if.cfg_valid  = 1'b1;
    cfg5_if.cfg_ch     = ch;
    cfg5_if.cfg_mode   = mode;
    cfg5_if.cfg_period = 8'd0;
    step();
    cfg5_if.cfg_valid  = 1'b0;
    step();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_ch      = '0;
    cfg_if.cfg_mode    = MODE_OFF;
    cfg_if.cfg_period  = '0;
    cfg5_if.cfg_valid  = 1'b0;
    cfg5_if.cfg_ch     = '0;
    cfg5_if.cfg_mode   = MODE_OFF;
    cfg5_if.cfg_period = '0;

    // Reset state, observed before any clock edge.
    p_reset_n = 1'b0;
    #1;
    chk("rst_led",   32'(led),           32'd0);
    chk("rst_wrap",  32'(wrap),          32'd0);
    chk("rst_busy",  32'(busy),          32'd0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("rst_mode",  32'(dbg_mode),      32'd0);
    step();
    step();
    p_reset_n = 1'b1;
    step();

`ifdef LED_BLINK_PRESCALE_EN
    begin
      int   prev = -1;
      int   nw   = 0;
      logic el   = 1'b0;
      cfg_wr(2'd0, MODE_BLINK, 8'd1);
      for (int k = 1; k <= 100; k++) begin
        step();
        if (wrap[0]) begin
          el = ~el;
          nw++;
          chk("presc_led", 32'(led[0]), 32'(el));
          if (prev >= 0) chk("presc_gap", 32'(k - prev), 32'd20);
          prev = k;
        end
      end
      chk("presc_nwraps", 32'(nw >= 4), 32'd1);
    end
`else
    // BLINK period=3 on ch0: toggle every 4 cycles, wrap with each toggle.
    cfg_wr(2'd0, MODE_BLINK, 8'd3);
    chk("blink_led0",  32'(led),         32'd0);
    chk("blink_mode0", 32'(dbg_mode[1:0]), 32'(MODE_BLINK));
    for (int k = 1; k <= 12; k++) begin
      step();
      e_led  = ((k / 4) % 2 == 1) ? 4'b0001 : 4'b0000;
      e_wrap = (k % 4 == 0) ? 4'b0001 : 4'b0000;
      chk("blink_led",  32'(led),  32'(e_led));
      chk("blink_wrap", 32'(wrap), 32'(e_wrap));
    end

    // Asynchronous reset mid-blink (led0=1, wrap0=1 right now).
    p_reset_n = 1'b0;
    #1;
    chk("arst_led",   32'(led),              32'd0);
    chk("arst_wrap",  32'(wrap),             32'd0);
    chk("arst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    step();
    p_reset_n = 1'b1;
    step();
    step();
    chk("arst_resume_led",  32'(led),      32'd0);
    chk("arst_resume_mode", 32'(dbg_mode), 32'd0);

    // ONESHOT period=5 on ch2: on for 6 cycles, single wrap, then OFF.
    cfg_wr(2'd2, MODE_ONESHOT, 8'd5);
    chk("os_led0",  32'(led),  32'b0100);
    chk("os_busy0", 32'(busy), 32'b0100);
    for (int k = 1; k <= 7; k++) begin
      step();
      e_led  = (k < 6) ? 4'b0100 : 4'b0000;
      e_wrap = (k == 6) ? 4'b0100 : 4'b0000;
      chk("os_led",  32'(led),  32'(e_led));
      chk("os_busy", 32'(busy), 32'(e_led));
      chk("os_wrap", 32'(wrap), 32'(e_wrap));
    end
    chk("os_mode_off", 32'(dbg_mode[5:4]), 32'(MODE_OFF));

    // period=0: BLINK toggles every tick, ONESHOT lasts one tick.
    cfg_wr(2'd2, MODE_BLINK, 8'd0);
    chk("p0_blink_k0", 32'(led), 32'd0);
    step();
    chk("p0_blink_led1",  32'(led),  32'b0100);
    chk("p0_blink_wrap1", 32'(wrap), 32'b0100);
    step();
    chk("p0_blink_led2",  32'(led),  32'b0000);
    chk("p0_blink_wrap2", 32'(wrap), 32'b0100);
    cfg_wr(2'd2, MODE_OFF, 8'd0);
    chk("off_led", 32'(led), 32'd0);
    cfg_wr(2'd1, MODE_ONESHOT, 8'd0);
    chk("p0_os_led0",  32'(led),  32'b0010);
    chk("p0_os_busy0", 32'(busy), 32'b0010);
    step();
    chk("p0_os_led1",  32'(led),  32'b0000);
    chk("p0_os_busy1", 32'(busy), 32'b0000);
    chk("p0_os_wrap1", 32'(wrap), 32'b0010);

    // Back-to-back requests: ready pattern 1,0,1,0,1.
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = 2'd1;
    cfg_if.cfg_mode   = MODE_ON;
    cfg_if.cfg_period = 8'd0;
    chk("b2b_ready", 32'(cfg_if.cfg_ready), exp_q.pop_front());
    step();
    chk("b2b_ready", 32'(cfg_if.cfg_ready), exp_q.pop_front());
    chk("b2b_led_a", 32'(led), 32'b0010);
    cfg_if.cfg_ch = 2'd3;
    step();
    chk("b2b_ready", 32'(cfg_if.cfg_ready), exp_q.pop_front());
    chk("b2b_led_b", 32'(led), 32'b0010);
    step();
    chk("b2b_ready", 32'(cfg_if.cfg_ready), exp_q.pop_front());
    chk("b2b_led_c", 32'(led), 32'b1010);
    cfg_if.cfg_valid = 1'b0;
    step();
    chk("b2b_ready", 32'(cfg_if.cfg_ready), exp_q.pop_front());
    chk("b2b_on_wrap", 32'(wrap), 32'd0);

    // Rewrite ch0 in its terminal-count cycle; other channels undisturbed.
    cfg_wr(2'd0, MODE_BLINK, 8'd3);
    chk("rw_k0", 32'(led), 32'b1010);
    step();
    step();
    step();
    chk("rw_k3", 32'(led), 32'b1010);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = 2'd0;
    cfg_if.cfg_mode   = MODE_BLINK;
    cfg_if.cfg_period = 8'd3;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("rw_led_k4",   32'(led),              32'b1010);
    chk("rw_wrap_k4",  32'(wrap),             32'd0);
    chk("rw_ready_k4", 32'(cfg_if.cfg_ready), 32'd0);
    step();
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = 2'd1;
    cfg_if.cfg_mode   = MODE_OFF;
    cfg_if.cfg_period = 8'd0;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("rw_led_k6", 32'(led), 32'b1000);
    step();
    chk("rw_led_k7",  32'(led),  32'b1000);
    chk("rw_wrap_k7", 32'(wrap), 32'd0);
    step();
    chk("rw_led_k8",  32'(led),  32'b1001);
    chk("rw_wrap_k8", 32'(wrap), 32'b0001);

    // All-ones period on ch3: toggle every 256 cycles.
    cfg_wr(2'd3, MODE_BLINK, 8'd255);
    chk("p255_k0", 32'(led[3]), 32'd0);
    for (int k = 1; k <= 512; k++) begin
      step();
      if (k == 255) begin
        chk("p255_led_255",  32'(led[3]),  32'd0);
        chk("p255_wrap_255", 32'(wrap[3]), 32'd0);
      end
      if (k == 256) begin
        chk("p255_led_256",  32'(led[3]),  32'd1);
        chk("p255_wrap_256", 32'(wrap[3]), 32'd1);
      end
      if (k == 511) begin
        chk("p255_led_511",  32'(led[3]),  32'd1);
        chk("p255_wrap_511", 32'(wrap[3]), 32'd0);
      end
      if (k == 512) begin
        chk("p255_led_512",  32'(led[3]),  32'd0);
        chk("p255_wrap_512", 32'(wrap[3]), 32'd1);
      end
    end

    // Out-of-range channel indices on the CH=5 instance.
    cfg5_wr(3'd5, MODE_ON);
    chk("oor5_led",  32'(led5), 32'd0);
    chk("oor5_mode", 32'(dbg5), 32'd0);
    cfg5_wr(3'd7, MODE_ON);
    chk("oor7_led", 32'(led5), 32'd0);
    cfg5_wr(3'd4, MODE_ON);
    chk("ch4_led", 32'(led5), 32'b10000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
